// File: rtl/pixel_frame_parser_pkg.sv
// pixel_frame_parser_pkg: frame-format constants shared with the pixel data generator.
// SOF/EOF markers, default PHL_ID, header byte offsets and parser state encoding.
package pixel_frame_parser_pkg;

  localparam logic [15:0] PFP_SOF    = 16'hFFEA;
  localparam logic [7:0]  PFP_EOF0   = 8'hAA;
  localparam logic [7:0]  PFP_EOF1   = 8'hDD;
  localparam logic [7:0]  PFP_PHL_ID = 8'h00;

  localparam int PFP_WORD_BYTES = 6;

  localparam int HDR_DTYPE_LSB = 0;
  localparam int HDR_DLEN3_LSB = 8;
  localparam int HDR_DLEN2_LSB = 16;
  localparam int HDR_DLEN1_LSB = 24;
  localparam int HDR_DLEN0_LSB = 32;
  localparam int HDR_PHL_LSB   = 40;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TAIL    = 2'd3
  } pfp_state_t;

endpackage

// File: rtl/pixel_frame_parser_hdr_decode.sv
// pixel_hdr_decode: unscrambles a header word into PHL_ID, DLEN, DTYPE.
// range_ok flags 1 <= DLEN <= MAX_DLEN, compared at full 32 bits.
module pixel_hdr_decode
  import pixel_frame_parser_pkg::*;
#(
  parameter int MAX_DLEN = 43
) (
  input  logic [47:0] hdr_word,
  output logic [7:0]  phl_id,
  output logic [31:0] dlen,
  output logic [7:0]  dtype,
  output logic        range_ok
);

  assign phl_id = hdr_word[HDR_PHL_LSB +: 8];
  assign dtype  = hdr_word[HDR_DTYPE_LSB +: 8];

  assign dlen = {
    hdr_word[HDR_DLEN3_LSB +: 8],
    hdr_word[HDR_DLEN2_LSB +: 8],
    hdr_word[HDR_DLEN1_LSB +: 8],
    hdr_word[HDR_DLEN0_LSB +: 8]
  };

  assign range_ok = (dlen != 32'd0)
                 && (dlen <= 32'(MAX_DLEN));

endmodule

// File: rtl/pixel_frame_parser.sv
// pixel_frame_parser: finds SOF, decodes header, unpacks payload, checks EOF.
// Optional idle watchdog mid-frame: define PIXEL_PARSER_TIMEOUT_EN.
module pixel_frame_parser
  import pixel_frame_parser_pkg::*;
#(
  parameter int         MAX_DLEN = 43,
  parameter logic [7:0] PHL_ID   = PFP_PHL_ID,
  parameter int         TIMEOUT  = 1024
) (
  input  logic                  rx_pixel_clk,
  input  logic                  rstn,
  input  logic [47:0]           pixel_value,
  input  logic                  pixel_valid,
  output logic [MAX_DLEN*8-1:0] data_out,
  output logic [31:0]           data_len,
  output logic [7:0]            dtype,
  output logic                  data_valid,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int KW = $clog2(MAX_DLEN + PFP_WORD_BYTES);

  if (MAX_DLEN < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("pixel_frame_parser: bad MAX_DLEN/TIMEOUT");
  end

  pfp_state_t    state;
  logic [KW-1:0] k;
  logic [31:0]   dlen_r;
  logic [7:0]    dtype_r;
  logic [2:0]    rem_r;

  logic [7:0]  h_phl;
  logic [31:0] h_dlen;
  logic [7:0]  h_dtype;
  logic        h_range_ok;

  pixel_hdr_decode #(
    .MAX_DLEN (MAX_DLEN)
  ) u_hdr (
    .hdr_word (pixel_value),
    .phl_id   (h_phl),
    .dlen     (h_dlen),
    .dtype    (h_dtype),
    .range_ok (h_range_ok)
  );

  logic        is_sof;
  logic        is_last;
  logic [31:0] k_ext;
  logic [15:0] eof_pair;

  assign is_sof   = pixel_value[15:0] == PFP_SOF;
  assign k_ext    = 32'(k);
  assign is_last  = (dlen_r - k_ext) == 32'(rem_r);
  assign eof_pair = 16'(pixel_value >> {rem_r, 3'b000});
  assign busy     = state != ST_IDLE;

  logic [7:0]          mem [MAX_DLEN];
  logic [MAX_DLEN-1:0] byte_we;
  logic [7:0]          byte_wd [MAX_DLEN];

  // byte-lane steering: word byte i lands at k+i, never at or past DLEN
  always_comb begin
    byte_we = '0;
    for (int n = 0; n < MAX_DLEN; n++) begin
      byte_wd[n] = 8'h00;
      if (state == ST_PAYLOAD && pixel_valid
          && 32'(n) < dlen_r) begin
        for (int i = 0; i < PFP_WORD_BYTES; i++) begin
          if (k_ext + 32'(i) == 32'(n)) begin
            byte_we[n] = 1'b1;
            byte_wd[n] = pixel_value[8*i +: 8];
          end
        end
      end
    end
  end

  // payload byte store, written in place
  always_ff @(posedge rx_pixel_clk) begin
    if (!rstn) begin
      for (int n = 0; n < MAX_DLEN; n++)
        mem[n] <= 8'h00;
    end else begin
      for (int n = 0; n < MAX_DLEN; n++)
        if (byte_we[n]) mem[n] <= byte_wd[n];
    end
  end

  for (genvar g = 0; g < MAX_DLEN; g++) begin : g_out
    assign data_out[8*g +: 8] = mem[g];
  end

`ifdef PIXEL_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
`endif

  // frame FSM with registered status outputs
  always_ff @(posedge rx_pixel_clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      k          <= '0;
      dlen_r     <= '0;
      dtype_r    <= '0;
      rem_r      <= '0;
      data_len   <= '0;
      dtype      <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PIXEL_PARSER_TIMEOUT_EN
      idle_cnt   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (pixel_valid) begin
        unique case (state)
          ST_IDLE: begin
            if (is_sof) begin
              state      <= ST_HDR;
              data_valid <= 1'b0;
            end
          end
          ST_HDR: begin
            if (h_phl == PHL_ID && h_range_ok) begin
              dlen_r  <= h_dlen;
              dtype_r <= h_dtype;
              rem_r   <= 3'(h_dlen % 32'd6);
              k       <= '0;
              state   <= ST_PAYLOAD;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            if (!is_last) begin
              k <= k + KW'(PFP_WORD_BYTES);
            end else if (rem_r == 3'd0 && is_sof) begin
              // no payload byte here, so a SOF restarts the frame
              frame_err <= 1'b1;
              state     <= ST_HDR;
            end else if (rem_r == 3'd5) begin
              if (eof_pair[7:0] == PFP_EOF0) begin
                state <= ST_TAIL;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
              end
            end else if (eof_pair == {PFP_EOF1, PFP_EOF0}) begin
              frame_done <= 1'b1;
              data_valid <= 1'b1;
              data_len   <= dlen_r;
              dtype      <= dtype_r;
              state      <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          ST_TAIL: begin
            if (pixel_value[7:0] == PFP_EOF1) begin
              frame_done <= 1'b1;
              data_valid <= 1'b1;
              data_len   <= dlen_r;
              dtype      <= dtype_r;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
`ifdef PIXEL_PARSER_TIMEOUT_EN
      if (pixel_valid || state == ST_IDLE) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
        idle_cnt  <= '0;
        frame_err <= 1'b1;
        state     <= ST_IDLE;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pixel_frame_parser.sv
// tb_pixel_frame_parser: table vectors, directed corner cases, random frames.
// Expected results come from frame-level rules and a byte image of data_out.
module tb_pixel_frame_parser;
  import pixel_frame_parser_pkg::*;

  localparam int MAX_DLEN = 43;
  localparam int TO       = 16;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [47:0]           pixel_value;
  logic                  pixel_valid;
  logic [MAX_DLEN*8-1:0] data_out;
  logic [31:0]           data_len;
  logic [7:0]            dtype;
  logic                  data_valid;
  logic                  frame_done;
  logic                  frame_err;
  logic                  busy;

  always #5 clk = ~clk;

  pixel_frame_parser #(
    .MAX_DLEN (MAX_DLEN),
    .PHL_ID   (8'h00),
    .TIMEOUT  (TO)
  ) dut (
    .rx_pixel_clk (clk),
    .rstn         (rstn),
    .pixel_value  (pixel_value),
    .pixel_valid  (pixel_valid),
    .data_out     (data_out),
    .data_len     (data_len),
    .dtype        (dtype),
    .data_valid   (data_valid),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;
  int n_err    = 0;

  logic [7:0]  exp_mem [MAX_DLEN];
  logic [47:0] fq [$];

  typedef struct {
    logic [31:0] dlen;
    logic [7:0]  phl;
    logic [7:0]  dt;
    int          corrupt;
    int          gapn;
    bit          exp_done;
  } vec_t;

  vec_t tbl [13];

  always @(negedge clk) begin
    if (rstn) begin
      if (frame_done) n_done++;
      if (frame_err)  n_err++;
    end
    if (frame_done && frame_err) begin
      failures++;
      $display("FAIL exclusive done=1 err=1 required not both");
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_data(input string nm);
    logic [MAX_DLEN*8-1:0] e;
    for (int i = 0; i < MAX_DLEN; i++) e[8*i +: 8] = exp_mem[i];
    checks++;
    if (data_out !== e) begin
      failures++;
      $display("FAIL %s data_out actual=%h required=%h", nm, data_out, e);
    end
  endtask

  task automatic word(input logic [47:0] w);
    pixel_value = w;
    pixel_valid = 1'b1;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    pixel_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < MAX_DLEN; i++) exp_mem[i] = 8'h00;
  endtask

  function automatic bit model_pass(input logic [31:0] dl,
                                    input logic [7:0] phl,
                                    input int cor);
    return phl == 8'h00 && dl >= 1 && dl <= MAX_DLEN && cor == 0;
  endfunction

  // builds fq and records every payload byte the frame would write
  task automatic build(input logic [31:0] dl, input logic [7:0] phl,
                       input logic [7:0] dt, input int cor);
    logic [7:0]  pay [$];
    logic [47:0] w;
    int nfull, rem;
    fq.delete();
    fq.push_back({32'($urandom), PFP_SOF});
    fq.push_back({phl, dl[7:0], dl[15:8], dl[23:16], dl[31:24], dt});
    if (!(phl == 8'h00 && dl >= 1 && dl <= MAX_DLEN)) return;
    for (int i = 0; i < int'(dl); i++) begin
      pay.push_back(8'($urandom));
      exp_mem[i] = pay[i];
    end
    nfull = int'(dl) / 6;
    rem   = int'(dl) % 6;
    for (int j = 0; j < nfull; j++) begin
      for (int i = 0; i < 6; i++) w[8*i +: 8] = pay[6*j + i];
      fq.push_back(w);
    end
    w = 48'({$urandom, $urandom});
    for (int i = 0; i < rem; i++) w[8*i +: 8] = pay[6*nfull + i];
    w[8*rem +: 8] = (cor == 1) ? 8'h55 : 8'hAA;
    if (rem < 5) begin
      w[8*(rem+1) +: 8] = (cor == 2) ? 8'h11 : 8'hDD;
      fq.push_back(w);
    end else begin
      fq.push_back(w);
      fq.push_back({40'($urandom), ((cor == 2) ? 8'h00 : 8'hDD)});
    end
  endtask

  task automatic run_frame(input logic [31:0] dl, input logic [7:0] phl,
                           input logic [7:0] dt, input int cor,
                           input int gapn, input bit exp_done,
                           input string tag);
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    build(dl, phl, dt, cor);
    foreach (fq[j]) begin
      word(fq[j]);
      if (gapn > 0) gap(gapn);
    end
    gap(2);
    chk({tag, ".done"}, 64'(n_done - d0), 64'(exp_done));
    chk({tag, ".err"}, 64'(n_err - e0), 64'(!exp_done));
    chk({tag, ".valid"}, 64'(data_valid), 64'(exp_done));
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    if (exp_done) begin
      chk({tag, ".len"}, 64'(data_len), 64'(dl));
      chk({tag, ".dtype"}, 64'(dtype), 64'(dt));
    end
    chk_data(tag);
  endtask

  initial begin
    int d0, e0;
    tbl[0]  = '{32'd43, 8'h00, 8'h01, 0, 0, 1'b1};
    tbl[1]  = '{32'd6, 8'h00, 8'h22, 0, 0, 1'b1};
    tbl[2]  = '{32'd6, 8'h00, 8'h23, 0, 3, 1'b1};
    tbl[3]  = '{32'd5, 8'h00, 8'h33, 0, 0, 1'b1};
    tbl[4]  = '{32'd5, 8'h00, 8'h34, 2, 0, 1'b0};
    tbl[5]  = '{32'd60, 8'h00, 8'h44, 0, 0, 1'b0};
    tbl[6]  = '{32'd43, 8'h05, 8'h45, 0, 0, 1'b0};
    tbl[7]  = '{32'd0, 8'h00, 8'h46, 0, 0, 1'b0};
    tbl[8]  = '{32'd1, 8'h00, 8'h47, 0, 0, 1'b1};
    tbl[9]  = '{32'h0100002B, 8'h00, 8'h48, 0, 0, 1'b0};
    tbl[10] = '{32'd12, 8'h00, 8'h49, 1, 0, 1'b0};
    tbl[11] = '{32'd44, 8'h00, 8'h50, 0, 0, 1'b0};
    tbl[12] = '{32'd42, 8'h00, 8'h51, 0, 1, 1'b1};

    pixel_valid = 1'b0;
    pixel_value = '0;
    rstn        = 1'b0;
    for (int i = 0; i < MAX_DLEN; i++) exp_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.data_out", 64'(data_out != '0), 64'd0);
    chk("rst.data_len", 64'(data_len), 64'd0);
    chk("rst.dtype", 64'(dtype), 64'd0);
    chk("rst.valid", 64'(data_valid), 64'd0);
    chk("rst.done", 64'(frame_done), 64'd0);
    chk("rst.err", 64'(frame_err), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    gap(1);

    for (int t = 0; t < 13; t++)
      run_frame(tbl[t].dlen, tbl[t].phl, tbl[t].dt, tbl[t].corrupt,
                tbl[t].gapn, tbl[t].exp_done, $sformatf("vec%0d", t));

    // latency of done, then a SOF in the very next cycle
    d0 = n_done;
    build(32'd43, 8'h00, 8'h61, 0);
    for (int j = 0; j < fq.size() - 1; j++) word(fq[j]);
    word(fq[fq.size() - 1]);
    chk("lat.done", 64'(frame_done), 64'd1);
    chk("lat.valid", 64'(data_valid), 64'd1);
    chk("lat.len", 64'(data_len), 64'd43);
    build(32'd6, 8'h00, 8'h62, 0);
    word(fq[0]);
    chk("lat.pulse", 64'(frame_done), 64'd0);
    chk("b2b.valid_clr", 64'(data_valid), 64'd0);
    for (int j = 1; j < fq.size(); j++) word(fq[j]);
    gap(2);
    chk("b2b.done", 64'(n_done - d0), 64'd2);
    chk("b2b.dtype", 64'(dtype), 64'h62);
    chk_data("b2b");

    // reset mid-frame
    e0 = n_err;
    build(32'd43, 8'h00, 8'h71, 0);
    for (int j = 0; j < 5; j++) word(fq[j]);
    do_reset();
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.valid", 64'(data_valid), 64'd0);
    chk("midrst.len", 64'(data_len), 64'd0);
    chk("midrst.err", 64'(n_err - e0), 64'd0);
    chk_data("midrst");
    run_frame(32'd17, 8'h00, 8'h72, 0, 0, 1'b1, "postrst");

    // SOF in the REM=0 final slot restarts; SOF-like payload is data
    build(32'd6, 8'h00, 8'h81, 0);
    for (int j = 0; j < 3; j++) word(fq[j]);
    word({32'h0, PFP_SOF});
    chk("restart.busy", 64'(busy), 64'd1);
    d0 = n_done;
    build(32'd12, 8'h00, 8'h82, 0);
    fq[2][15:0] = PFP_SOF;
    exp_mem[0] = 8'hEA;
    exp_mem[1] = 8'hFF;
    for (int j = 1; j < fq.size(); j++) word(fq[j]);
    gap(2);
    chk("restart.done", 64'(n_done - d0), 64'd1);
    chk("restart.len", 64'(data_len), 64'd12);
    chk_data("restart");

    // idle watchdog mid-payload
    e0 = n_err;
    build(32'd43, 8'h00, 8'h91, 0);
    for (int j = 0; j < 3; j++) word(fq[j]);
`ifdef PIXEL_PARSER_TIMEOUT_EN
    gap(TO - 1);
    chk("tmo.busy_before", 64'(busy), 64'd1);
    chk("tmo.err_before", 64'(n_err - e0), 64'd0);
    gap(1);
    chk("tmo.err", 64'(frame_err), 64'd1);
    chk("tmo.busy", 64'(busy), 64'd0);
`else
    gap(3 * TO);
    chk("notmo.busy", 64'(busy), 64'd1);
    chk("notmo.err", 64'(n_err - e0), 64'd0);
`endif
    do_reset();

    // random frames against the frame-level model
    for (int r = 0; r < 40; r++) begin
      logic [31:0] dl;
      logic [7:0]  phl;
      int          cor;
      dl = 32'($urandom_range(0, 50));
      if ($urandom_range(0, 9) == 0) dl = $urandom;
      phl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255))
                                        : 8'h00;
      cor = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_frame(dl, phl, 8'($urandom), cor, int'($urandom_range(0, 2)),
                model_pass(dl, phl, cor), $sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 2)) word(48'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
